alu_result_buffer: RTL

Two-entry elastic buffer directly downstream of the ALU in the execute stage of the Core101 pipeline. It captures `result_out` from the ALU together with the destination register tag and write-enable, then presents them to writeback over a valid/ready handshake. This decouples ALU issue from writeback stalls without dropping results. It optionally exports the oldest buffered result as a forwarding source.

---
 rtl/alu_result_buffer_pkg.sv | 13 +
 rtl/alu_result_buffer_entry.sv | 32 +++
 rtl/alu_result_buffer.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_result_buffer_pkg.sv
// Shared constants for the execute-stage ALU result buffer.
// Optional forwarding export is enabled with ALU_RESULT_BUFFER_FWD_EN.
package alu_result_buffer_pkg;

    localparam int unsigned XLEN_DEFAULT    = 32;
    localparam int unsigned RADDR_W_DEFAULT = 5;

    localparam int unsigned WB_EN_W = 1;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned COUNT_W   = 2;

endpackage

// File: rtl/alu_result_buffer_entry.sv
// One storage slot of the ALU result buffer: loads on write, clears synchronously.
// Used by alu_result_buffer (see ALU_RESULT_BUFFER_FWD_EN there).
module result_entry_reg
    import alu_result_buffer_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned RADDR_W = RADDR_W_DEFAULT
) (
    input  logic               clock_in,
    input  logic               clear_in,
    input  logic               write_in,
    input  logic [XLEN-1:0]    result_in,
    input  logic [RADDR_W-1:0] rd_addr_in,
    input  logic [WB_EN_W-1:0] wb_en_in,
    output logic [XLEN-1:0]    result_out,
    output logic [RADDR_W-1:0] rd_addr_out,
    output logic [WB_EN_W-1:0] wb_en_out
);

    always_ff @(posedge clock_in) begin
        if (clear_in) begin
            result_out  <= '0;
            rd_addr_out <= '0;
            wb_en_out   <= '0;
        end else if (write_in) begin
            result_out  <= result_in;
            rd_addr_out <= rd_addr_in;
            wb_en_out   <= wb_en_in;
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Two-entry elastic buffer between the ALU and writeback, valid/ready on both sides.
// Define ALU_RESULT_BUFFER_FWD_EN to export the head entry as a forwarding source.
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned RADDR_W = RADDR_W_DEFAULT
) (
    input  logic               clock_in,
    input  logic               reset_in,
    input  logic               flush_in,
    input  logic               valid_in,
    input  logic [XLEN-1:0]    result_in,
    input  logic [RADDR_W-1:0] rd_addr_in,
    input  logic               wb_en_in,
    output logic               ready_out,
    output logic               valid_out,
    output logic [XLEN-1:0]    result_out,
    output logic [RADDR_W-1:0] rd_addr_out,
    output logic               wb_en_out,
    input  logic               ready_in
`ifdef ALU_RESULT_BUFFER_FWD_EN
    ,
    output logic               fwd_valid_out,
    output logic [RADDR_W-1:0] fwd_addr_out,
    output logic [XLEN-1:0]    fwd_data_out
`endif
);

    logic [COUNT_W-1:0] count;
    logic               rd_ptr;
    logic               wr_ptr;
    logic               do_push;
    logic               do_pop;
    logic               wb_en_store;

    logic [XLEN-1:0]    entry_result [BUF_DEPTH];
    logic [RADDR_W-1:0] entry_rd     [BUF_DEPTH];
    logic [WB_EN_W-1:0] entry_wb     [BUF_DEPTH];

    // Ready and valid come from registered count only, so no ready_in -> ready_out path.
    assign ready_out = (count != COUNT_W'(BUF_DEPTH));
    assign valid_out = (count != '0);

    assign do_push = valid_in && ready_out && !flush_in;
    assign do_pop  = valid_out && ready_in && !flush_in;

    // Writes to x0 never reach the register file, so drop the enable at capture.
    assign wb_en_store = wb_en_in && (rd_addr_in != '0);

    for (genvar i = 0; i < BUF_DEPTH; i++) begin : g_entry
        result_entry_reg #(
            .XLEN    (XLEN),
            .RADDR_W (RADDR_W)
        ) u_entry (
            .clock_in    (clock_in),
            .clear_in    (reset_in),
            .write_in    (do_push && (wr_ptr == 1'(i))),
            .result_in   (result_in),
            .rd_addr_in  (rd_addr_in),
            .wb_en_in    (wb_en_store),
            .result_out  (entry_result[i]),
            .rd_addr_out (entry_rd[i]),
            .wb_en_out   (entry_wb[i])
        );
    end

    always_ff @(posedge clock_in) begin
        if (reset_in || flush_in) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head fields are zeroed when empty so stale slots never leak downstream.
    always_comb begin
        result_out  = '0;
        rd_addr_out = '0;
        wb_en_out   = 1'b0;
        if (valid_out) begin
            result_out  = entry_result[rd_ptr];
            rd_addr_out = entry_rd[rd_ptr];
            wb_en_out   = entry_wb[rd_ptr][0];
        end
    end

`ifdef ALU_RESULT_BUFFER_FWD_EN
    assign fwd_valid_out = valid_out && wb_en_out;
    assign fwd_addr_out  = rd_addr_out;
    assign fwd_data_out  = result_out;
`endif

endmodule
